// File: rtl/jlsemi_util_async_req_arb_pkg.sv
// Shared definitions for the asynchronous request arbiter.
//   arb_state_t : arbiter FSM state encoding
//   arb_pick_t  : result of a round-robin pick (found flag + winner index)
//   arb_rr_pick : round-robin scan starting one past the last winner
package jlsemi_util_arb_pkg;

   localparam int ARB_MAX_REQ  = 16;
   localparam int ARB_MAX_ID_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                    found;
      logic [ARB_MAX_ID_W-1:0] id;
   } arb_pick_t;

   // Scans last+1, last+2, ... modulo num and returns the first set request.
   // Only the first num positions of req are looked at.
   function automatic arb_pick_t arb_rr_pick(
      input logic [ARB_MAX_REQ-1:0]  req,
      input logic [ARB_MAX_ID_W-1:0] last,
      input int                      num
   );
      arb_pick_t               res;
      logic [ARB_MAX_ID_W-1:0] idx;
      res.found = 1'b0;
      res.id    = {ARB_MAX_ID_W{1'b0}};
      for (int k = 1; k <= ARB_MAX_REQ; k++) begin
         idx = ARB_MAX_ID_W'((int'(last) + k) % num);
         if ((k <= num) && !res.found && req[idx]) begin
            res.found = 1'b1;
            res.id    = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/jlsemi_util_async_req_arb_if.sv
// Handshake bundle between the arbiter and its requesters / local consumer.
//   req_async : level requests from foreign domains (4-phase)
//   ack_async : level acks back to the requesters
//   gnt_vld   : grant active toward the local consumer
//   gnt_id    : granted requester index (0 when no grant)
//   gnt_done  : one-cycle pulse from the consumer, service finished
//   busy      : arbiter not idle
//   err_abort : one-cycle pulse, granted request dropped before gnt_done
// slave modport = arbiter side, master modport = requester/consumer side.
interface jlsemi_util_async_req_arb_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_async;
   logic [NUM_REQ-1:0] ack_async;
   logic               gnt_vld;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_done;
   logic               busy;
   logic               err_abort;

   modport slave (
      input  req_async, gnt_done,
      output ack_async, gnt_vld, gnt_id, busy, err_abort
   );

   modport master (
      output req_async, gnt_done,
      input  ack_async, gnt_vld, gnt_id, busy, err_abort
   );
endinterface

// File: rtl/jlsemi_util_async_req_arb_sync.sv
// Single-bit STEP-deep flop synchronizer with active-high asynchronous reset.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears the chain
//   d   : asynchronous input bit
//   q   : synchronized output, d delayed STEP clk edges
module jlsemi_util_sync_pos_with_rst_high #(
   parameter int STEP = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   // The chain must stay as discrete flops so the metastability margin is kept.
   (* dont_touch = "true" *) logic [STEP-1:0] sync_r;

   // Shift the input through the synchronizer chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {STEP{1'b0}};
      end else begin
         sync_r <= {sync_r[STEP-2:0], d};
      end
   end

   assign q = sync_r[STEP-1];
endmodule

// File: rtl/jlsemi_util_async_req_arb.sv
// Round-robin arbiter for NUM_REQ asynchronous four-phase requesters sharing
// one resource in the clk domain.
//   clk : single clock for all logic
//   rst : asynchronous active-high reset
//   bus : slave side of jlsemi_util_async_req_arb_if (requests, acks, grant)
module jlsemi_util_async_req_arb
   import jlsemi_util_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int SYNC_STEP = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   jlsemi_util_async_req_arb_if.slave  bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_sync_s;
   arb_pick_t          pick_s;
   logic               pick_ok_s;

   arb_state_t         state_r, state_nxt_s;
   logic [ID_W-1:0]    cur_id_r, cur_id_nxt_s;
   logic [ID_W-1:0]    last_r, last_nxt_s;
   logic [ID_W-1:0]    gnt_id_r, gnt_id_nxt_s;
   logic               gnt_vld_r, gnt_vld_nxt_s;
   logic               err_abort_r, err_abort_nxt_s;
   logic               busy_r;
   logic [NUM_REQ-1:0] ack_r, ack_nxt_s;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
      jlsemi_util_sync_pos_with_rst_high #(
         .STEP (SYNC_STEP)
      ) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (bus.req_async[i]),
         .q   (req_sync_s[i])
      );
   end

   assign pick_s = arb_rr_pick(ARB_MAX_REQ'(req_sync_s), ARB_MAX_ID_W'(last_r), NUM_REQ);
   // A winner outside the requester range is never granted.
   assign pick_ok_s = pick_s.found && (int'(pick_s.id) < NUM_REQ);

   // Next-state and next-output decode of the arbiter FSM.
   always_comb begin
      state_nxt_s     = state_r;
      cur_id_nxt_s    = cur_id_r;
      last_nxt_s      = last_r;
      gnt_id_nxt_s    = gnt_id_r;
      gnt_vld_nxt_s   = gnt_vld_r;
      ack_nxt_s       = ack_r;
      err_abort_nxt_s = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (pick_ok_s) begin
               state_nxt_s   = ARB_GRANT;
               cur_id_nxt_s  = ID_W'(pick_s.id);
               gnt_id_nxt_s  = ID_W'(pick_s.id);
               gnt_vld_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            // gnt_done has priority over a simultaneous request drop.
            if (bus.gnt_done) begin
               state_nxt_s          = ARB_RELEASE;
               ack_nxt_s[cur_id_r]  = 1'b1;
               gnt_vld_nxt_s        = 1'b0;
               gnt_id_nxt_s         = {ID_W{1'b0}};
            end else if (!req_sync_s[cur_id_r]) begin
               state_nxt_s     = ARB_IDLE;
               gnt_vld_nxt_s   = 1'b0;
               gnt_id_nxt_s    = {ID_W{1'b0}};
               err_abort_nxt_s = 1'b1;
               last_nxt_s      = cur_id_r;
            end else begin
               state_nxt_s = ARB_GRANT;
            end
         end
         ARB_RELEASE: begin
            if (!req_sync_s[cur_id_r]) begin
               state_nxt_s = ARB_IDLE;
               ack_nxt_s   = {NUM_REQ{1'b0}};
               last_nxt_s  = cur_id_r;
            end else begin
               state_nxt_s = ARB_RELEASE;
            end
         end
         default: begin
            state_nxt_s   = ARB_IDLE;
            gnt_vld_nxt_s = 1'b0;
            gnt_id_nxt_s  = {ID_W{1'b0}};
            ack_nxt_s     = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // State and output registers; all outputs come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ARB_IDLE;
         cur_id_r    <= {ID_W{1'b0}};
         last_r      <= ID_W'(NUM_REQ - 1);
         gnt_id_r    <= {ID_W{1'b0}};
         gnt_vld_r   <= 1'b0;
         ack_r       <= {NUM_REQ{1'b0}};
         err_abort_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cur_id_r    <= cur_id_nxt_s;
         last_r      <= last_nxt_s;
         gnt_id_r    <= gnt_id_nxt_s;
         gnt_vld_r   <= gnt_vld_nxt_s;
         ack_r       <= ack_nxt_s;
         err_abort_r <= err_abort_nxt_s;
         busy_r      <= (state_nxt_s != ARB_IDLE);
      end
   end

   assign bus.ack_async = ack_r;
   assign bus.gnt_vld   = gnt_vld_r;
   assign bus.gnt_id    = gnt_id_r;
   assign bus.busy      = busy_r;
   assign bus.err_abort = err_abort_r;
endmodule

// File: tb/tb_jlsemi_util_async_req_arb.sv
// Self-checking bench for jlsemi_util_async_req_arb: directed scenarios and
// random four-phase traffic, compared each cycle against a reference model.
module tb_jlsemi_util_async_req_arb;
   localparam int N  = 4;
   localparam int S  = 2;

   logic clk;
   logic rst;

   jlsemi_util_async_req_arb_if #(.NUM_REQ(N)) bus_if ();

   jlsemi_util_async_req_arb #(
      .NUM_REQ   (N),
      .SYNC_STEP (S)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: request history for the synchronizer delay, and who
   // currently holds the grant / the ack (-1 = nobody).
   logic [N-1:0] m_pipe [S];
   int           m_grant;
   int           m_ack;
   int           m_last;
   logic         m_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] one_hot(input int i);
      logic [N-1:0] one;
      one = {{(N-1){1'b0}}, 1'b1};
      return one << i;
   endfunction

   function automatic logic bit_at(input logic [N-1:0] v, input int i);
      return (v & one_hot(i)) != {N{1'b0}};
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < S; s++) m_pipe[s] = {N{1'b0}};
      m_grant = -1;
      m_ack   = -1;
      m_last  = N - 1;
      m_err   = 1'b0;
   endfunction

   function automatic void model_step(input logic [N-1:0] req, input logic done);
      logic [N-1:0] seen;
      int           c;
      seen = m_pipe[S-1];
      for (int s = S - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
      m_pipe[0] = req;
      m_err = 1'b0;
      if (m_grant >= 0) begin
         if (done) begin
            m_ack   = m_grant;
            m_grant = -1;
         end else if (!bit_at(seen, m_grant)) begin
            m_err   = 1'b1;
            m_last  = m_grant;
            m_grant = -1;
         end
      end else if (m_ack >= 0) begin
         if (!bit_at(seen, m_ack)) begin
            m_last = m_ack;
            m_ack  = -1;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (m_grant < 0 && bit_at(seen, c)) m_grant = c;
         end
      end
   endfunction

   task automatic compare_all();
      logic [N-1:0] exp_ack;
      exp_ack = (m_ack >= 0) ? one_hot(m_ack) : {N{1'b0}};
      check_val("ack_async", 32'(bus_if.ack_async), 32'(exp_ack));
      check_val("gnt_vld",   32'(bus_if.gnt_vld),   32'(m_grant >= 0));
      check_val("gnt_id",    32'(bus_if.gnt_id),    (m_grant >= 0) ? 32'(m_grant) : 32'd0);
      check_val("busy",      32'(bus_if.busy),      32'((m_grant >= 0) || (m_ack >= 0)));
      check_val("err_abort", 32'(bus_if.err_abort), 32'(m_err));
   endtask

   // Called at a negedge: drive inputs, let one active edge pass, check.
   task automatic step(input logic [N-1:0] req, input logic done);
      bus_if.req_async = req;
      bus_if.gnt_done  = done;
      @(posedge clk);
      model_step(req, done);
      @(negedge clk);
      compare_all();
   endtask

   // Asynchronous reset in mid-cycle; outputs must clear before any edge.
   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      check_val("rst_ack",     32'(bus_if.ack_async), 32'd0);
      check_val("rst_gnt_vld", 32'(bus_if.gnt_vld),   32'd0);
      check_val("rst_gnt_id",  32'(bus_if.gnt_id),    32'd0);
      check_val("rst_busy",    32'(bus_if.busy),      32'd0);
      check_val("rst_err",     32'(bus_if.err_abort), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      compare_all();
   endtask

   initial begin
      logic [N-1:0] rr_req;
      logic [N-1:0] rq;
      logic [N-1:0] mask;
      logic         d;

      rst = 1'b0;
      bus_if.req_async = {N{1'b0}};
      bus_if.gnt_done  = 1'b0;
      model_reset();
      @(negedge clk);
      pulse_reset();

      // Spurious gnt_done while idle.
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b0);
      check_val("spurious_busy", 32'(bus_if.busy), 32'd0);

      // Single request on 2: grant two edges after sync, ack on done.
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      check_val("single_vld_early", 32'(bus_if.gnt_vld), 32'd0);
      step(4'b0100, 1'b0);
      check_val("single_vld", 32'(bus_if.gnt_vld), 32'd1);
      check_val("single_id",  32'(bus_if.gnt_id),  32'd2);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b1);
      check_val("single_ack", 32'(bus_if.ack_async), 32'h4);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      check_val("single_ack_hold", 32'(bus_if.ack_async), 32'h4);
      step(4'b0000, 1'b0);
      check_val("single_ack_drop", 32'(bus_if.ack_async), 32'h0);
      check_val("single_busy",     32'(bus_if.busy),      32'd0);

      // Abort: grant 1, request 1 withdrawn while 2 becomes pending.
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      check_val("abort_grant_id", 32'(bus_if.gnt_id), 32'd1);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b0);
      check_val("abort_err", 32'(bus_if.err_abort), 32'd1);
      check_val("abort_vld", 32'(bus_if.gnt_vld),   32'd0);
      check_val("abort_ack", 32'(bus_if.ack_async), 32'h0);
      step(4'b0100, 1'b0);
      check_val("abort_err_once", 32'(bus_if.err_abort), 32'd0);
      check_val("abort_next_id",  32'(bus_if.gnt_id),    32'd2);
      step(4'b0100, 1'b1);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // gnt_done arriving on the same edge the request drop is seen.
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);
      check_val("simul_id", 32'(bus_if.gnt_id), 32'd3);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      check_val("simul_ack", 32'(bus_if.ack_async), 32'h8);
      check_val("simul_err", 32'(bus_if.err_abort), 32'd0);
      step(4'b0000, 1'b0);
      check_val("simul_ack_clr", 32'(bus_if.ack_async), 32'h0);

      // Reset while in RELEASE holding ack 3; afterwards req 0 wins.
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b1000, 1'b1);
      step(4'b1000, 1'b0);
      check_val("release_ack", 32'(bus_if.ack_async), 32'h8);
      pulse_reset();
      step(4'b1001, 1'b0);
      step(4'b1001, 1'b0);
      step(4'b1001, 1'b0);
      check_val("post_rst_id", 32'(bus_if.gnt_id), 32'd0);
      step(4'b1001, 1'b1);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      pulse_reset();

      // Round-robin with all four requesting: 0,1,2,3,0.
      rr_req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         for (int c = 0; c < 12 && !bus_if.gnt_vld; c++) step(rr_req, 1'b0);
         check_val("rr_vld", 32'(bus_if.gnt_vld), 32'd1);
         check_val("rr_id",  32'(bus_if.gnt_id),  32'(j % N));
         step(rr_req, 1'b1);
         rr_req = rr_req & ~one_hot(j % N);
         for (int c = 0; c < 12 && bus_if.ack_async != {N{1'b0}}; c++) step(rr_req, 1'b0);
         check_val("rr_ack_clr", 32'(bus_if.ack_async), 32'h0);
         rr_req = rr_req | one_hot(j % N);
      end

      // Random protocol traffic with occasional early withdrawals.
      rq = {N{1'b0}};
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            mask = one_hot(i);
            if ((rq & mask) == {N{1'b0}}) begin
               if (m_ack != i && $urandom_range(0, 3) == 0) rq = rq | mask;
            end else if (m_ack == i) begin
               if ($urandom_range(0, 2) == 0) rq = rq & ~mask;
            end else if ($urandom_range(0, 40) == 0) begin
               rq = rq & ~mask;
            end
         end
         d = (m_grant >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         if (cyc == 1000) pulse_reset();
         step(rq, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
